// File: rtl/aes_sbox_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox_pkg
// Brief    : Shared definitions for sbox_engine: FSM state type and the
//            FIPS-197 forward / inverse S-box tables. The inverse table is
//            compiled in only when SBOX_ENGINE_INV_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package aes_sbox_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0] SBOX_FWD [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

`ifdef SBOX_ENGINE_INV_EN
   localparam logic [7:0] SBOX_INV [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };
`endif

endpackage
`default_nettype wire

// File: rtl/sbox_lane.sv
`default_nettype none
// ============================================================================
// Module   : sbox_lane
// Brief    : One combinational AES S-box byte lookup. With SBOX_ENGINE_INV_EN
//            defined, i_inv selects the inverse table; otherwise i_inv is
//            ignored and the forward S-box is always applied.
// Revision : 1.0 - initial release
// ============================================================================
module sbox_lane
   import aes_sbox_pkg::*;
(
   input  logic [7:0] i_byte,
   input  logic       i_inv,
   output logic [7:0] o_byte
);

`ifdef SBOX_ENGINE_INV_EN
   // Table select: inverse when requested, forward otherwise
   always_comb begin
      o_byte = SBOX_FWD[i_byte];
      if (i_inv) begin
         o_byte = SBOX_INV[i_byte];
      end
   end
`else
   // Mode input has no effect in a forward-only build
   logic w_unused_inv;
   assign w_unused_inv = i_inv;

   // Forward-only lookup
   always_comb begin
      o_byte = SBOX_FWD[i_byte];
   end
`endif

endmodule
`default_nettype wire

// File: rtl/sbox_engine.sv
`default_nettype none
// ============================================================================
// Module   : sbox_engine
// Brief    : Multi-cycle AES SubBytes engine. A block of NBYTES bytes is
//            captured in IDLE, substituted LANES bytes per cycle in RUN, and
//            presented in DONE until the consumer handshakes.
//            Optional feature macro: SBOX_ENGINE_INV_EN (inverse S-box).
// Revision : 1.0 - initial release
// ============================================================================
module sbox_engine
   import aes_sbox_pkg::*;
#(
   parameter int NBYTES = 16,
   parameter int LANES  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_inv,
   input  logic [8*NBYTES-1:0]   in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NBYTES-1:0]   out_data,
   output logic                  busy
);

   // Number of beats per block and the width of the beat counter
   localparam int B  = NBYTES / LANES;
   localparam int BW = (B > 1) ? $clog2(B) : 1;

   // Working register viewed as B groups of LANES bytes; bit layout matches
   // in_data so byte i lives at [8i+7:8i].
   state_t                          r_state;
   logic [BW-1:0]                   r_beat;
   logic [B-1:0][LANES-1:0][7:0]    r_work;
   logic                            r_inv;

   logic [LANES-1:0][7:0]           w_group;
   logic [LANES-1:0][7:0]           w_sub;
   logic                            w_last_beat;

   assign w_group     = r_work[r_beat];
   assign w_last_beat = (r_beat == BW'(B - 1));

   // One lookup lane per byte of the current beat group
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      sbox_lane u_lane (
         .i_byte (w_group[l]),
         .i_inv  (r_inv),
         .o_byte (w_sub[l])
      );
   end

   // Block FSM: capture in IDLE, substitute one group per cycle in RUN,
   // hold the result in DONE until the consumer takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_beat  <= '0;
         r_work  <= '0;
         r_inv   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_work  <= in_data;
                  r_inv   <= in_inv;
                  r_beat  <= '0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_work[r_beat] <= w_sub;
               r_beat         <= r_beat + 1'b1;
               if (w_last_beat) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Handshake and status outputs derived directly from the state; the
   // result bus is gated so partial work never leaves the block
   always_comb begin
      in_ready  = (r_state == ST_IDLE);
      out_valid = (r_state == ST_DONE);
      busy      = (r_state != ST_IDLE);
      out_data  = (r_state == ST_DONE) ? r_work : '0;
   end

endmodule
`default_nettype wire

// File: doc/sbox_engine.md
SBOX_ENGINE -- requirements
Module: sbox_engine

Interface
REQ-001 SHALL have parameter NBYTES, default 16: bytes per block; legal values 4, 8, 16.
REQ-002 SHALL have parameter LANES, default 4: S-box lookups per cycle; legal values 1, 2, 4, 8, 16; LANES divides NBYTES; LANES <= NBYTES.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: input block offered.
REQ-006 SHALL have port in_ready, output, 1 bit: engine accepts a block this cycle.
REQ-007 SHALL have port in_inv, input, 1 bit: 1 = inverse S-box, 0 = forward; sampled with the block.
REQ-008 SHALL have port in_data, input, 8*NBYTES bits: byte i at [8i+7:8i].
REQ-009 SHALL have port out_valid, output, 1 bit: result block valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port out_data, output, 8*NBYTES bits: substituted block, same byte order as in_data.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL hold in_ready=1 only in IDLE.
REQ-015 SHALL accept a block on a clock edge where in_valid && in_ready; at that edge it captures in_data and in_inv, clears beat counter to 0 and moves to RUN.
REQ-016 SHALL, in RUN, replace bytes beat*LANES .. beat*LANES+LANES-1 of the working register with their S-box values on each edge, then increment beat.
REQ-017 SHALL move to DONE on the edge that processes beat B-1, where B = NBYTES/LANES; beat SHALL be $clog2(B) bits wide, minimum 1 bit.
REQ-018 SHALL assert out_valid exactly B cycles after the accepting edge and hold out_valid and out_data stable until out_ready.
REQ-019 SHALL return from DONE to IDLE on an edge where out_valid && out_ready; a new block SHALL be accepted no earlier than the following edge, giving minimum block period B+2 cycles.
REQ-020 SHALL ignore in_valid, in_inv and in_data outside IDLE; SHALL ignore out_ready outside DONE.
REQ-021 SHALL give each byte the FIPS-197 S-box (forward) or inverse S-box value; bytes not yet processed SHALL never appear on out_data while out_valid=1.
REQ-022 SHALL handle LANES=NBYTES (B=1) with one RUN cycle; out_valid SHALL then rise 1 cycle after acceptance.
REQ-023 SHALL use mode fixed per block; a change to in_inv after acceptance SHALL have no effect.

Reset
REQ-024 SHALL, while rst_n=0, immediately force state=IDLE, beat=0, working register=0, out_valid=0, busy=0, in_ready=1, out_data=0.
REQ-025 SHALL discard any in-flight block when reset is asserted mid-RUN or mid-DONE; no partial result SHALL be presented after release.
REQ-026 SHALL allow the first block to be accepted on the first clock edge after rst_n deasserts.

Configuration
REQ-027 SHALL compile in the inverse table and honour in_inv when macro SBOX_ENGINE_INV_EN is defined.
REQ-028 SHALL, without SBOX_ENGINE_INV_EN, omit the inverse table, ignore in_inv and always apply the forward S-box; the port SHALL remain present.

Structure
REQ-029 SHALL place the state enum typedef, forward table constant SBOX_FWD[256] and inverse table constant SBOX_INV[256] (inverse guarded by the macro) in shared package aes_sbox_pkg.
REQ-030 SHALL use sub-module sbox_lane: one combinational byte lookup with byte in, inv in, byte out; instantiated LANES times.

Verification
REQ-031 SHALL cover: NBYTES=16, LANES=4, forward, in_data all 0x00 -> out_valid 4 cycles after accept, out_data all 0x63.
REQ-032 SHALL cover: forward byte0=0x53, byte1=0xff, byte2=0x01, rest 0x00 -> byte0=0xed, byte1=0x16, byte2=0x7c, rest 0x63.
REQ-033 SHALL cover: SBOX_ENGINE_INV_EN defined, in_inv=1, all bytes 0x63 -> all 0x00; byte0=0x16 -> 0xff. Without the macro the same stimulus -> forward result, byte0=0x47.
REQ-034 SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_valid/out_data stable, in_ready=0, second in_valid not accepted until after the handshake.
REQ-035 SHALL cover: rst_n pulsed low in RUN beat 2 -> out_valid never asserts for that block; next block after release returns its correct result.
REQ-036 SHALL cover: LANES=16, NBYTES=16, back-to-back in_valid with out_ready=1 -> out_valid 1 cycle after each accept, accepts spaced 3 cycles apart.
